// File: rtl/mac_ctrl_pkg.sv
// mac_ctrl_pkg: shared state encoding and default widths for the MAC dot-product sequencer.
package mac_ctrl_pkg;
    localparam int DEF_DW      = 16;
    localparam int DEF_ACC_W   = 36;
    localparam int DEF_LEN_W   = 8;
    localparam int DEF_MAC_LAT = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ACCUM,
        ST_DRAIN,
        ST_DONE
    } state_t;
endpackage

// File: rtl/mac_len_counter.sv
// mac_len_counter: loadable down-counter tracking the remaining operand beats of a job.
module mac_len_counter
    import mac_ctrl_pkg::*;
#(
    parameter int W = DEF_LEN_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         is_one,
    output logic         is_zero
);
    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec && count != '0)
            count <= count - 1'b1;
    end

    assign is_one  = count == W'(1);
    assign is_zero = count == '0;
endmodule

// File: rtl/mac_dot_ctrl.sv
// mac_dot_ctrl: sequences one LEN-pair dot product through an external 16x16 MAC and
// hands the sum off on a valid/ready result port.
module mac_dot_ctrl
    import mac_ctrl_pkg::*;
#(
    parameter int DW      = DEF_DW,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int MAC_LAT = DEF_MAC_LAT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_a,
    input  logic [DW-1:0]    in_b,
    output logic [DW-1:0]    mac_a,
    output logic [DW-1:0]    mac_b,
    output logic             mac_clr_n,
    input  logic [ACC_W-1:0] mac_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_data
);
    localparam int DRN_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    state_t           state, state_nx;
    logic             beat, accept, is_one, is_zero, drn_last;
    logic [DRN_W-1:0] drn;

    assign accept   = state == ST_IDLE && start;
    assign beat     = in_valid && in_ready;
    assign drn_last = state == ST_DRAIN && drn == '0;

    mac_len_counter #(.W(LEN_W)) u_len_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .dec      (beat),
        .load_val (len),
        .is_one   (is_one),
        .is_zero  (is_zero)
    );

    always_ff @(posedge clk) begin
        if (!reset)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  state_nx = start ? ST_CLEAR : ST_IDLE;
            ST_CLEAR: state_nx = is_zero ? ST_DRAIN : ST_ACCUM;
            ST_ACCUM: state_nx = (beat && is_one) ? ST_DRAIN : ST_ACCUM;
            ST_DRAIN: state_nx = drn_last ? ST_DONE : ST_DRAIN;
            ST_DONE:  state_nx = res_ready ? ST_IDLE : ST_DONE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Drain counter reloads whenever outside DRAIN so every drain lasts exactly MAC_LAT cycles.
    always_ff @(posedge clk) begin
        if (!reset)
            drn <= '0;
        else if (state != ST_DRAIN)
            drn <= DRN_W'(MAC_LAT - 1);
        else if (drn != '0)
            drn <= drn - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset)
            res_data <= '0;
        else if (drn_last)
            res_data <= mac_out;
    end

    assign busy      = state != ST_IDLE;
    assign in_ready  = state == ST_ACCUM;
    assign res_valid = state == ST_DONE;
    // Held in clear while reset is low so an aborted job leaves nothing in the MAC.
    assign mac_clr_n = reset && state != ST_CLEAR;
    assign mac_a     = beat ? in_a : '0;
    assign mac_b     = beat ? in_b : '0;
endmodule

// File: tb/tb_mac_dot_ctrl.sv
// tb_mac_dot_ctrl: scoreboard bench pairing mac_dot_ctrl with a behavioural 2-stage MAC.
module tb_mac_dot_ctrl;
    localparam int DW = 16, ACC_W = 36, LEN_W = 8;

    logic             clk = 0, reset = 0, start = 0, in_valid = 0, res_ready = 0;
    logic [LEN_W-1:0] len = '0;
    logic [DW-1:0]    in_a = '0, in_b = '0;
    logic             busy, in_ready, mac_clr_n, res_valid;
    logic [DW-1:0]    mac_a, mac_b;
    logic [ACC_W-1:0] mac_out, res_data;
    logic [2*DW-1:0]  prod;

    int               checks = 0, errors = 0;
    logic [ACC_W-1:0] exp_q[$];
    logic [ACC_W-1:0] last_res = '0, held = '0;
    logic             waiting = 0;
    logic [DW-1:0]    va[256], vb[256];
    bit               vpat[8];
    int               vpat_len = 0;

    always #5 clk = ~clk;

    mac_dot_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .len(len), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mac_a(mac_a), .mac_b(mac_b), .mac_clr_n(mac_clr_n), .mac_out(mac_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
    );

    // Stand-in for the real MAC: product register, then accumulator.
    always @(posedge clk) begin
        if (!mac_clr_n) begin
            prod    <= '0;
            mac_out <= '0;
        end else begin
            prod    <= {16'b0, mac_a} * {16'b0, mac_b};
            mac_out <= mac_out + ACC_W'(prod);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && res_valid) begin
            if (waiting) chk("res_hold", res_data, held);
            if (res_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL res_unexpected: got %0h expected no result", res_data);
                end else begin
                    last_res = res_data;
                    chk("res_data", res_data, exp_q.pop_front());
                end
            end
            held    = res_data;
            waiting = !res_ready;
        end else begin
            waiting = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input int n, input int stall_pct, input int hold, input bit poke);
        logic [ACC_W-1:0] sum = '0;
        int  i = 0, k = 1, stalls = 0;
        bit  xr, done = 0;
        for (int j = 0; j < n; j++) sum += ACC_W'(va[j]) * ACC_W'(vb[j]);
        exp_q.push_back(sum);
        start = 1;
        len   = LEN_W'(n);
        step();
        start = 0;
        len   = LEN_W'($urandom);
        while (!done) begin
            xr = k >= 2 && i < n;
            if (vpat_len > 0)
                in_valid = i < n && (k >= 2 ? vpat[(k - 2) % vpat_len] : 1'b0);
            else
                in_valid = i < n && $urandom_range(99) >= stall_pct;
            in_a = in_valid ? va[i] : DW'($urandom);
            in_b = in_valid ? vb[i] : DW'($urandom);
            if (poke && $urandom_range(3) == 0) begin
                start = 1;
                len   = LEN_W'($urandom);
            end
            #1;
            chk("in_ready", in_ready, xr);
            chk("mac_a", mac_a, (in_valid && xr) ? in_a : '0);
            chk("mac_b", mac_b, (in_valid && xr) ? in_b : '0);
            chk("busy", busy, 1);
            if (xr && !in_valid) stalls++;
            if (xr && in_valid) i++;
            step();
            k++;
            start    = 0;
            in_valid = 0;
            if (res_valid) done = 1;
            else if (k > 10 + n + stalls) begin
                checks++;
                errors++;
                $display("FAIL res_timeout: no res_valid after %0d cycles, len %0d", k, n);
                done = 1;
            end
        end
        chk("latency", k, 4 + n + stalls);
        for (int h = 0; h < hold; h++) begin
            if (poke) begin
                start = 1;
                len   = LEN_W'($urandom);
            end
            chk("res_valid_wait", res_valid, 1);
            step();
            start = 0;
        end
        res_ready = 1;
        step();
        res_ready = 0;
        chk("busy_after", busy, 0);
        chk("res_valid_after", res_valid, 0);
    endtask

    initial begin
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_mac_clr_n", mac_clr_n, 0);
        chk("rst_mac_a", mac_a, 0);
        chk("rst_mac_b", mac_b, 0);
        reset = 1;
        step();
        chk("idle_mac_clr_n", mac_clr_n, 1);

        for (int j = 0; j < 4; j++) begin
            va[j] = DW'(j + 1);
            vb[j] = DW'(j + 5);
        end
        run_job(4, 0, 0, 0);
        chk("dot_70", last_res, 70);

        va[0] = 16'hFFFF; va[1] = 16'hFFFF; va[2] = 16'hFFFF;
        vb[0] = 16'hFFFF; vb[1] = 16'hFFFF; vb[2] = 16'hFFFF;
        vpat[0] = 1; vpat[1] = 0; vpat[2] = 0; vpat[3] = 1; vpat[4] = 0; vpat[5] = 1;
        vpat_len = 6;
        run_job(3, 0, 1, 0);
        vpat_len = 0;
        chk("dot_max", last_res, 36'h2FFFA0003);

        run_job(0, 0, 0, 0);
        chk("dot_len0", last_res, 0);

        va[0] = 3; vb[0] = 3; va[1] = 4; vb[1] = 4;
        run_job(2, 0, 5, 1);
        chk("dot_25", last_res, 25);
        va[0] = 2; vb[0] = 5;
        run_job(1, 0, 0, 0);
        chk("dot_10", last_res, 10);

        for (int j = 0; j < 5; j++) begin
            va[j] = DW'($urandom);
            vb[j] = DW'($urandom);
        end
        start = 1;
        len   = 5;
        step();
        start    = 0;
        in_valid = 1;
        in_a     = va[0];
        in_b     = vb[0];
        step();
        step();
        in_valid = 0;
        reset    = 0;
        step();
        reset = 1;
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 0);
        chk("abort_res_data", res_data, 0);
        step();
        chk("abort_res_valid", res_valid, 0);
        va[0] = 7; vb[0] = 9;
        run_job(1, 0, 0, 0);
        chk("dot_63", last_res, 63);

        for (int t = 0; t < 30; t++) begin
            int n;
            n = ($urandom_range(9) == 0) ? $urandom_range(60, 20) : $urandom_range(12);
            for (int j = 0; j < n; j++) begin
                va[j] = DW'($urandom);
                vb[j] = DW'($urandom);
            end
            run_job(n, $urandom_range(70), $urandom_range(3), 1);
        end

        step();
        step();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
